// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation sequencer. For each request it walks RESP_BITS
// consecutive challenges. Each challenge is raced NUM_EVAL times through a
// settle (arbiter cleared), launch and sample cycle. The synchronized arbiter
// decisions for a challenge are majority-voted into one response bit.
module puf_eval_ctrl #(
  parameter int NUM_EVAL   = 7,
  parameter int SETTLE_CYC = 4,
  parameter int RACE_CYC   = 4,
  parameter int RESP_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           challenge,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic [7:0]           puf_challenge,
  output logic                 puf_launch,
  output logic                 arb_clear,
  input  logic                 arb_out
);

  localparam int BIT_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state;
  logic [7:0]       tmr;
  logic [7:0]       ones_cnt;
  logic [7:0]       eval_cnt;
  logic [BIT_W-1:0] bit_idx;
  logic [7:0]       cur_chal;
  logic             arb_sync_p0;
  logic             arb_sync_p1;
  logic [7:0]       ones_nxt;
  logic [7:0]       eval_nxt;

  // Strict majority: more than half of the evaluations returned 1.
  function automatic logic majority(input logic [7:0] ones);
    logic [8:0] dbl;
    dbl = {ones, 1'b0};
    return dbl > 9'(NUM_EVAL);
  endfunction

  // arb_out is asynchronous to clk; only arb_sync_p1 is ever consumed.
  always_ff @(posedge clk) begin
    arb_sync_p0 <= arb_out;
    arb_sync_p1 <= arb_sync_p0;
  end

  assign ones_nxt = ones_cnt + {7'd0, arb_sync_p1};
  assign eval_nxt = eval_cnt + 8'd1;

  // Output decode straight from state so reset drops the launch at once.
  always_comb begin
    busy       = (state == S_SETUP) || (state == S_LAUNCH) || (state == S_SAMPLE);
    done       = (state == S_DONE);
    puf_launch = (state == S_LAUNCH) || (state == S_SAMPLE);
    arb_clear  = (state == S_SETUP);
  end

  // Sequencer: settle/launch timers, vote accumulation and challenge stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      tmr           <= 8'd0;
      ones_cnt      <= 8'd0;
      eval_cnt      <= 8'd0;
      bit_idx       <= '0;
      cur_chal      <= 8'd0;
      puf_challenge <= 8'd0;
      response      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_chal      <= challenge;
            puf_challenge <= challenge;
            bit_idx       <= '0;
            eval_cnt      <= 8'd0;
            ones_cnt      <= 8'd0;
            tmr           <= 8'd0;
            response      <= '0;
            state         <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr == 8'(SETTLE_CYC - 1)) begin
            tmr   <= 8'd0;
            state <= S_LAUNCH;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        S_LAUNCH: begin
          if (tmr == 8'(RACE_CYC - 1)) begin
            tmr   <= 8'd0;
            state <= S_SAMPLE;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        S_SAMPLE: begin
          if (eval_nxt < 8'(NUM_EVAL)) begin
            ones_cnt <= ones_nxt;
            eval_cnt <= eval_nxt;
            state    <= S_SETUP;
          end else begin
            response[bit_idx] <= majority(ones_nxt);
            ones_cnt          <= 8'd0;
            eval_cnt          <= 8'd0;
            cur_chal          <= cur_chal + 8'd1;
            if (bit_idx == BIT_W'(RESP_BITS - 1)) begin
              state <= S_DONE;
            end else begin
              // The displayed challenge only moves when a new bit begins.
              bit_idx       <= bit_idx + 1'b1;
              puf_challenge <= cur_chal + 8'd1;
              state         <= S_SETUP;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl with default parameters. A small arbiter
// model returns, per challenge, a chosen number of 1s out of 7 evaluations.
module tb_puf_eval_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] challenge;
  logic       busy;
  logic       done;
  logic [7:0] response;
  logic [7:0] puf_challenge;
  logic       puf_launch;
  logic       arb_clear;
  logic       arb_out = 1'b0;

  int total = 0;
  int bad   = 0;

  int         mode = 0;
  logic [7:0] base = 8'd0;
  int         run_id = 0;
  int         seen_id = 0;
  int         rise_cnt = 0;
  int         done_cnt = 0;
  logic       prev_launch = 1'b0;
  logic [7:0] prev_chal = 8'd0;

  puf_eval_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge),
    .busy(busy), .done(done), .response(response),
    .puf_challenge(puf_challenge), .puf_launch(puf_launch),
    .arb_clear(arb_clear), .arb_out(arb_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Number of 1 decisions (out of 7) the model gives for a challenge.
  function automatic int ones_for(input int m, input int idx, input logic [7:0] ch);
    if (m == 0) return 7;
    if (m == 1) begin
      case (idx)
        0: return 4;
        1: return 3;
        2: return 0;
        3: return 7;
        4: return 5;
        5: return 2;
        6: return 4;
        default: return 1;
      endcase
    end
    return ch[0] ? 6 : 1;
  endfunction

  // Arbiter model plus launch/clear and challenge-stability monitors.
  always @(negedge clk) begin
    int k;
    int idx;
    logic [7:0] exp_chal;
    if (run_id != seen_id) begin
      seen_id  = run_id;
      rise_cnt = 0;
    end
    if (puf_launch && !prev_launch) begin
      k        = rise_cnt % 7;
      idx      = rise_cnt / 7;
      arb_out  = (k < ones_for(mode, idx, puf_challenge));
      exp_chal = base + 8'(idx);
      if (k == 0) check("chal_step", puf_challenge, exp_chal);
      rise_cnt++;
    end
    if (arb_clear && puf_launch) check("clear_launch_overlap", 1, 0);
    if (puf_launch && prev_launch && (puf_challenge != prev_chal))
      check("chal_stable_in_launch", puf_challenge, prev_chal);
    if (done) done_cnt++;
    prev_launch = puf_launch;
    prev_chal   = puf_challenge;
  end

  // Starts a run at the current negedge and follows it to done.
  task automatic run(input logic [7:0] b, input int hold, input bit mid,
                     input logic [7:0] exp_resp, input string tag);
    int cyc;
    int lat;
    int d0;
    logic [1:0] exp_seq;
    base      = b;
    run_id++;
    challenge = b;
    start     = 1'b1;
    d0        = done_cnt;
    @(posedge clk);
    cyc = 0;
    lat = 0;
    while (cyc < 2000 && lat == 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == hold) start = 1'b0;
      if (mid && cyc == 200) start = 1'b1;
      if (mid && cyc == 203) start = 1'b0;
      if (cyc == 1) begin
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_resp_cleared"}, response, 0);
      end
      if (cyc <= 10) begin
        exp_seq = (cyc <= 4) ? 2'b01 : (cyc <= 9) ? 2'b10 : 2'b01;
        check({tag, "_launch_clear_seq"}, {puf_launch, arb_clear}, exp_seq);
      end
      if (done) lat = cyc;
    end
    check({tag, "_latency"}, lat, 505);
    check({tag, "_busy_in_done"}, busy, 0);
    check({tag, "_response"}, response, exp_resp);
    @(negedge clk);
    check({tag, "_done_width"}, done, 0);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_resp_hold"}, response, exp_resp);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    challenge = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_response", response, 0);
    check("rst_puf_challenge", puf_challenge, 0);
    check("rst_launch", puf_launch, 0);
    check("rst_arb_clear", arb_clear, 0);
    rst = 1'b0;
    @(negedge clk);

    mode = 0;
    run(8'h3C, 1, 1'b0, 8'hFF, "basic");

    @(negedge clk);
    mode = 1;
    run(8'h10, 1, 1'b0, 8'h59, "majority");

    // Back-to-back: start raised in the cycle right after done, held 3 cycles.
    mode = 2;
    run(8'hFE, 3, 1'b1, 8'hAA, "wrap");

    // Reset during LAUNCH of bit 3.
    @(negedge clk);
    mode = 0;
    base = 8'h80;
    run_id++;
    challenge = 8'h80;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rise_cnt < 22 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait_bit3", (rise_cnt >= 22), 1);
    check("pre_rst_launch", puf_launch, 1);
    check("pre_rst_response", response, 8'h07);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_launch", puf_launch, 0);
    check("midrst_response", response, 0);
    check("midrst_done", done, 0);
    check("midrst_arb_clear", arb_clear, 0);
    @(negedge clk);
    run(8'h21, 1, 1'b0, 8'hFF, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
